// File: rtl/mem_access_pkg.sv
// Pipeline types shared by the memory stage: control word, stage payloads, forwarding record.
// No logic of its own; no latency.
// No flow control of its own; the stages carry the handshakes.
package mem_access_pkg;

   typedef logic [63:0] word_t;
   typedef logic [4:0]  creg_addr_t;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic   reg_write;
      logic   mem_read;
      logic   mem_write;
      logic   mem_to_reg;
      msize_t mem_size;
      logic   mem_unsigned;
   } control_t;

   typedef struct packed {
      logic [31:0] instr;
      creg_addr_t  dst;
      word_t       aluout;
      word_t       memdata;
      control_t    ctl;
   } exec_data_t;

   typedef struct packed {
      logic [31:0] instr;
      creg_addr_t  dst;
      word_t       writedata;
      control_t    ctl;
   } mem_data_t;

   typedef struct packed {
      creg_addr_t dst;
      word_t      data;
      logic       valid;
   } fwd_data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store shift + strobe, load shift + sign/zero extend.
// Purely combinational, zero latency.
// No backpressure; follows its inputs.
module mem_lane_fmt
   import mem_access_pkg::*;
(
   input  logic [2:0] off,
   input  msize_t     size,
   input  logic       is_unsigned,
   input  word_t      st_data,
   input  word_t      ld_raw,
   output word_t      st_lane,
   output logic [7:0] st_strobe,
   output word_t      ld_val
);

   logic [7:0] mask;
   word_t      lane;

   always_comb begin
      mask = 8'h00;
      case (size)
         MSIZE1:  mask = 8'h01;
         MSIZE2:  mask = 8'h03;
         MSIZE4:  mask = 8'h0F;
         default: mask = 8'hFF;
      endcase
      // Shifting an 8-bit mask drops lanes past byte 7, so misaligned strobes truncate.
      st_strobe = mask << off;
      st_lane   = st_data << {off, 3'b000};
      lane      = ld_raw >> {off, 3'b000};
      case (size)
         MSIZE1:  ld_val = is_unsigned ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
         MSIZE2:  ld_val = is_unsigned ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
         MSIZE4:  ld_val = is_unsigned ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
         default: ld_val = lane;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// RV64 memory stage: issues loads/stores on a two-phase addr_ok/data_ok bus, formats loads (fwd gated by MEM_FWD_EN).
// Latency: 1 cycle for non-memory ops, 2+ cycles for memory ops (data_ok in M gives out_valid in M+1).
// Backpressure: single-entry; in_ready only when empty or the held result leaves this cycle, never during flush.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  exec_data_t        in_data,
   output logic              in_ready,
   output logic              out_valid,
   output mem_data_t         out_data,
   input  logic              out_ready,
   input  logic              flush,
   output logic              dreq_valid,
   output logic [ADDR_W-1:0] dreq_addr,
   output msize_t            dreq_size,
   output logic [7:0]        dreq_strobe,
   output word_t             dreq_data,
   input  logic              dresp_addr_ok,
   input  logic              dresp_data_ok,
   input  word_t             dresp_data,
   output fwd_data_t         fwd
);

   mem_state_t state_q, state_d;
   exec_data_t ex_q;
   word_t      ld_q;
   word_t      st_lane;
   word_t      ld_val;
   logic [7:0] st_strobe;
   logic       flush_q, flush_d;
   logic       accept, in_is_mem, ld_en;

   assign in_is_mem = in_data.ctl.mem_read | in_data.ctl.mem_write;
   assign in_ready  = ((state_q == IDLE) | ((state_q == HOLD) & out_ready)) & ~flush;
   assign accept    = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      ld_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = in_is_mem ? REQ : HOLD;
         end
         HOLD: begin
            if (flush)          state_d = IDLE;
            else if (out_ready) state_d = accept ? (in_is_mem ? REQ : HOLD) : IDLE;
         end
         REQ, WAIT: begin
            // A bus request is never withdrawn; a flush only decides where completion lands.
            flush_d = flush_q | flush;
            if (dresp_data_ok & ((state_q == WAIT) | dresp_addr_ok)) begin
               ld_en   = 1'b1;
               flush_d = 1'b0;
               state_d = (flush_q | flush) ? IDLE : HOLD;
            end else if ((state_q == REQ) & dresp_addr_ok) begin
               state_d = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         flush_q <= 1'b0;
         ex_q    <= '0;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         if (accept) ex_q <= in_data;
         if (ld_en)  ld_q <= ld_val;
      end
   end

   mem_lane_fmt u_lane_fmt (
      .off         (ex_q.aluout[2:0]),
      .size        (ex_q.ctl.mem_size),
      .is_unsigned (ex_q.ctl.mem_unsigned),
      .st_data     (ex_q.memdata),
      .ld_raw      (dresp_data),
      .st_lane     (st_lane),
      .st_strobe   (st_strobe),
      .ld_val      (ld_val)
   );

   assign dreq_valid  = (state_q == REQ);
   assign dreq_addr   = ex_q.aluout[ADDR_W-1:0];
   assign dreq_size   = ex_q.ctl.mem_size;
   assign dreq_strobe = ex_q.ctl.mem_write ? st_strobe : 8'h00;
   assign dreq_data   = st_lane;

   assign out_valid          = (state_q == HOLD);
   assign out_data.instr     = ex_q.instr;
   assign out_data.dst       = ex_q.dst;
   assign out_data.ctl       = ex_q.ctl;
   assign out_data.writedata = ex_q.ctl.mem_to_reg ? ld_q : ex_q.aluout;

`ifdef MEM_FWD_EN
   assign fwd.valid = (state_q == HOLD) & ex_q.ctl.reg_write & (ex_q.dst != 5'd0);
   assign fwd.dst   = ex_q.dst;
   assign fwd.data  = out_data.writedata;
`else
   // Without forwarding the hazard unit must stall on any dependence on this stage.
   assign fwd = '0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a byte-level reference model and scoreboard.
module tb_mem_access;
   import mem_access_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_ready, out_valid, out_ready, flush;
   exec_data_t in_data;
   mem_data_t  out_data;
   logic       dreq_valid;
   logic [63:0] dreq_addr;
   msize_t     dreq_size;
   logic [7:0] dreq_strobe;
   word_t      dreq_data;
   logic       addr_ok, data_ok;
   word_t      dresp_data;
   fwd_data_t  fwd;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_access #(.ADDR_W(64)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready),
      .flush         (flush),
      .dreq_valid    (dreq_valid),
      .dreq_addr     (dreq_addr),
      .dreq_size     (dreq_size),
      .dreq_strobe   (dreq_strobe),
      .dreq_data     (dreq_data),
      .dresp_addr_ok (addr_ok),
      .dresp_data_ok (data_ok),
      .dresp_data    (dresp_data),
      .fwd           (fwd)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (byte lanes, plain arithmetic) ----------------
   function automatic int nbytes(input exec_data_t e);
      return 1 << int'(e.ctl.mem_size);
   endfunction

   function automatic logic [7:0] ref_strobe(input exec_data_t e);
      logic [7:0] s = 8'h00;
      int off = int'(e.aluout[2:0]);
      if (!e.ctl.mem_write) return 8'h00;
      for (int i = 0; i < nbytes(e); i++)
         if (off + i < 8) s[off+i] = 1'b1;
      return s;
   endfunction

   function automatic word_t ref_sdata(input exec_data_t e);
      word_t d = '0;
      int off = int'(e.aluout[2:0]);
      for (int i = 0; i + off < 8; i++) d[8*(off+i) +: 8] = e.memdata[8*i +: 8];
      return d;
   endfunction

   function automatic word_t ref_load(input exec_data_t e, input word_t raw);
      word_t v = '0;
      int off = int'(e.aluout[2:0]);
      int n = nbytes(e);
      for (int i = 0; i < n; i++)
         if (off + i < 8) v[8*i +: 8] = raw[8*(off+i) +: 8];
      if (!e.ctl.mem_unsigned && v[8*n-1])
         for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic mem_data_t ref_out(input exec_data_t e, input word_t raw);
      mem_data_t m;
      m.instr     = e.instr;
      m.dst       = e.dst;
      m.ctl       = e.ctl;
      m.writedata = e.ctl.mem_to_reg ? ref_load(e, raw) : e.aluout;
      return m;
   endfunction

   function automatic fwd_data_t exp_fwd(input mem_data_t m);
      fwd_data_t f = '0;
`ifdef MEM_FWD_EN
      f.valid = m.ctl.reg_write && (m.dst != 5'd0);
      f.dst   = m.dst;
      f.data  = m.writedata;
`endif
      return f;
   endfunction

   function automatic exec_data_t mk(input logic rd, input logic wr, input logic m2r, input logic rw,
                                      input msize_t sz, input logic uns, input word_t alu,
                                      input word_t md, input logic [4:0] dst);
      exec_data_t e = '0;
      e.instr            = 32'hC0DE_0000 | {27'd0, dst};
      e.dst              = dst;
      e.aluout           = alu;
      e.memdata          = md;
      e.ctl.mem_read     = rd;
      e.ctl.mem_write    = wr;
      e.ctl.mem_to_reg   = m2r;
      e.ctl.reg_write    = rw;
      e.ctl.mem_size     = sz;
      e.ctl.mem_unsigned = uns;
      return e;
   endfunction

   function automatic exec_data_t rnd_instr();
      exec_data_t e = '0;
      int k = $urandom_range(0, 2);
      e.instr        = $urandom;
      e.dst          = 5'($urandom);
      e.aluout       = {$urandom, $urandom};
      e.memdata      = {$urandom, $urandom};
      e.ctl.mem_size = msize_t'($urandom_range(0, 3));
      if (k == 0) begin
         e.ctl.reg_write = 1'b1;
      end else begin
         if (k == 1) begin
            e.ctl.mem_read     = 1'b1;
            e.ctl.mem_to_reg   = 1'b1;
            e.ctl.reg_write    = 1'b1;
            e.ctl.mem_unsigned = 1'($urandom);
         end else begin
            e.ctl.mem_write = 1'b1;
         end
         e.aluout[2:0] = e.aluout[2:0] & 3'(8 - nbytes(e));
      end
      return e;
   endfunction

   // ---------------- random-phase bus responder and scoreboard ----------------
   mem_data_t  expq[$];
   exec_data_t pend;
   int bus_ph = 0;
   int a_cnt  = 0;
   int d_cnt  = 0;

   task automatic rnd_cycle(input bit gen);
      mem_data_t m;
      cyc();
      addr_ok = 1'b0;
      data_ok = 1'b0;
      dresp_data = {$urandom, $urandom};
      if (bus_ph == 2) chk("rnd_wait_no_dreq", dreq_valid, 1'b0);
      if (bus_ph == 0 && dreq_valid) begin
         bus_ph = 1;
         a_cnt  = $urandom_range(0, 2);
      end
      if (bus_ph == 1) begin
         chk("rnd_dreq_valid", dreq_valid, 1'b1);
         chk("rnd_dreq_addr", dreq_addr, pend.aluout);
         chk("rnd_dreq_strobe", dreq_strobe, ref_strobe(pend));
         if (pend.ctl.mem_write) chk("rnd_dreq_data", dreq_data, ref_sdata(pend));
         if (a_cnt == 0) begin
            addr_ok = 1'b1;
            d_cnt   = $urandom_range(0, 3);
            bus_ph  = 2;
         end else a_cnt--;
      end
      if (bus_ph == 2) begin
         if (d_cnt == 0) begin
            data_ok = 1'b1;
            bus_ph  = 0;
            expq.push_back(ref_out(pend, dresp_data));
         end else d_cnt--;
      end
      in_valid  = gen && ($urandom_range(0, 2) != 0);
      in_data   = rnd_instr();
      out_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      #2;
      if (out_valid && out_ready) begin
         chk("rnd_out_expected", expq.size() != 0, 1'b1);
         if (expq.size() != 0) begin
            m = expq.pop_front();
            chk("rnd_writedata", out_data.writedata, m.writedata);
            chk("rnd_dst", out_data.dst, m.dst);
            chk("rnd_instr", out_data.instr, m.instr);
            chk("rnd_fwd", fwd, exp_fwd(m));
         end
      end else if (!out_valid) begin
         chk("rnd_fwd_idle", fwd.valid, 1'b0);
      end
      if (in_valid && in_ready) begin
         if (in_data.ctl.mem_read || in_data.ctl.mem_write) pend = in_data;
         else expq.push_back(ref_out(in_data, '0));
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      exec_data_t e;
      word_t      raw;
      logic [7:0] strb;
      word_t      sdat;
      word_t      wb;
   } vec_t;

   localparam int NV = 11;
   vec_t tv[NV];

   initial begin
      exec_data_t e;
      mem_data_t  m;
      word_t      held;
      logic       is_mem;

      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush = 1'b0;
      addr_ok = 1'b0; data_ok = 1'b0; dresp_data = '0;

      tv[0]  = '{e: mk(0,0,0,1,MSIZE8,0,64'h1234,64'h0,5),                 raw: 64'h0,
                 strb: 8'h00, sdat: 64'h0, wb: 64'h1234};
      tv[1]  = '{e: mk(1,0,1,1,MSIZE1,0,64'h1003,64'h0,6),                 raw: 64'h0000_0000_8000_0000,
                 strb: 8'h00, sdat: 64'h0, wb: 64'hFFFF_FFFF_FFFF_FF80};
      tv[2]  = '{e: mk(0,1,0,0,MSIZE2,0,64'h2006,64'hABCD,0),              raw: 64'h0,
                 strb: 8'hC0, sdat: 64'hABCD_0000_0000_0000, wb: 64'h2006};
      tv[3]  = '{e: mk(1,0,1,1,MSIZE8,0,64'h3000,64'h0,10),                raw: 64'h0123_4567_89AB_CDEF,
                 strb: 8'h00, sdat: 64'h0, wb: 64'h0123_4567_89AB_CDEF};
      tv[4]  = '{e: mk(0,1,0,0,MSIZE1,0,64'h7,64'h5A,0),                   raw: 64'h0,
                 strb: 8'h80, sdat: 64'h5A00_0000_0000_0000, wb: 64'h7};
      tv[5]  = '{e: mk(1,0,1,1,MSIZE2,1,64'h2,64'h0,11),                   raw: 64'h0000_0000_F00D_0000,
                 strb: 8'h00, sdat: 64'h0, wb: 64'h0000_0000_0000_F00D};
      tv[6]  = '{e: mk(1,0,1,1,MSIZE4,0,64'h4,64'h0,12),                   raw: 64'h8765_4321_0000_0000,
                 strb: 8'h00, sdat: 64'h0, wb: 64'hFFFF_FFFF_8765_4321};
      tv[7]  = '{e: mk(0,1,0,0,MSIZE4,0,64'hC,64'h1122_3344,0),            raw: 64'h0,
                 strb: 8'hF0, sdat: 64'h1122_3344_0000_0000, wb: 64'hC};
      tv[8]  = '{e: mk(1,0,1,1,MSIZE2,0,64'hE,64'h0,13),                   raw: 64'hFFEE_0000_0000_0000,
                 strb: 8'h00, sdat: 64'h0, wb: 64'hFFFF_FFFF_FFFF_FFEE};
      tv[9]  = '{e: mk(0,1,0,0,MSIZE8,0,64'h18,64'hDEAD_BEEF_CAFE_F00D,0), raw: 64'h0,
                 strb: 8'hFF, sdat: 64'hDEAD_BEEF_CAFE_F00D, wb: 64'h18};
      tv[10] = '{e: mk(0,0,0,1,MSIZE8,0,64'h55,64'h0,0),                   raw: 64'h0,
                 strb: 8'h00, sdat: 64'h0, wb: 64'h55};

      // reset state
      cyc(); cyc();
      reset = 1'b0;
      #2;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_dreq_valid", dreq_valid, 1'b0);
      chk("rst_dreq_addr", dreq_addr, 64'h0);
      chk("rst_dreq_strobe", dreq_strobe, 8'h00);
      chk("rst_dreq_data", dreq_data, 64'h0);
      chk("rst_fwd", fwd, '0);

      // table: every memory op answered with addr_ok & data_ok in its first request cycle
      for (int i = 0; i < NV; i++) begin
         is_mem = tv[i].e.ctl.mem_read | tv[i].e.ctl.mem_write;
         cyc();
         in_valid = 1'b1; in_data = tv[i].e; out_ready = 1'b1;
         #2;
         chk("vec_in_ready", in_ready, 1'b1);
         cyc();
         in_valid = 1'b0; in_data = '0;
         if (is_mem) begin
            addr_ok = 1'b1; data_ok = 1'b1; dresp_data = tv[i].raw;
            #2;
            chk("vec_dreq_valid", dreq_valid, 1'b1);
            chk("vec_dreq_addr", dreq_addr, tv[i].e.aluout);
            chk("vec_dreq_size", dreq_size, tv[i].e.ctl.mem_size);
            chk("vec_dreq_strobe", dreq_strobe, tv[i].strb);
            chk("vec_dreq_data", dreq_data, tv[i].sdat);
            chk("vec_out_valid_early", out_valid, 1'b0);
            cyc();
            addr_ok = 1'b0; data_ok = 1'b0; dresp_data = {$urandom, $urandom};
         end
         #2;
         m = '{instr: tv[i].e.instr, dst: tv[i].e.dst, writedata: tv[i].wb, ctl: tv[i].e.ctl};
         chk("vec_out_valid", out_valid, 1'b1);
         chk("vec_writedata", out_data.writedata, tv[i].wb);
         chk("vec_dst", out_data.dst, tv[i].e.dst);
         chk("vec_ctl", out_data.ctl, tv[i].e.ctl);
         chk("vec_fwd", fwd, exp_fwd(m));
      end

      // back-to-back non-memory ops, one per cycle
      for (int k = 0; k <= 4; k++) begin
         cyc();
         in_valid = (k < 4); in_data = mk(0,0,0,1,MSIZE8,0,64'h100 + 64'(k),64'h0,5'(k+1));
         #2;
         if (k < 4) chk("b2b_in_ready", in_ready, 1'b1);
         if (k > 0) begin
            chk("b2b_out_valid", out_valid, 1'b1);
            chk("b2b_writedata", out_data.writedata, 64'h100 + 64'(k-1));
         end
      end

      // SH with addr_ok only on the third request cycle
      cyc();
      in_valid = 1'b0; in_data = '0;
      #2;
      chk("sh_idle", out_valid, 1'b0);
      cyc();
      in_valid = 1'b1; in_data = tv[2].e;
      #2;
      for (int k = 0; k < 3; k++) begin
         cyc();
         in_valid = 1'b0; in_data = '0;
         addr_ok = (k == 2); data_ok = (k == 2);
         #2;
         chk("sh_dreq_valid", dreq_valid, 1'b1);
         chk("sh_dreq_strobe", dreq_strobe, 8'hC0);
         chk("sh_dreq_data", dreq_data, 64'hABCD_0000_0000_0000);
         chk("sh_in_ready", in_ready, 1'b0);
         chk("sh_fwd_valid", fwd.valid, 1'b0);
      end
      cyc();
      addr_ok = 1'b0; data_ok = 1'b0;
      #2;
      chk("sh_out_valid", out_valid, 1'b1);
      chk("sh_fwd_hold", fwd.valid, 1'b0);

      // LWU with data_ok four cycles after addr_ok
      cyc();
      in_valid = 1'b1; in_data = mk(1,0,1,1,MSIZE4,1,64'h0,64'h0,7);
      #2;
      for (int k = 0; k < 5; k++) begin
         cyc();
         in_valid = 1'b0; in_data = '0;
         addr_ok = (k == 0); data_ok = (k == 4);
         dresp_data = (k == 4) ? 64'h0000_0000_FFFF_FFFF : 64'h0;
         #2;
         chk("lwu_in_ready", in_ready, 1'b0);
         chk("lwu_dreq_valid", dreq_valid, k == 0);
      end
      cyc();
      addr_ok = 1'b0; data_ok = 1'b0;
      #2;
      chk("lwu_out_valid", out_valid, 1'b1);
      chk("lwu_writedata", out_data.writedata, 64'h0000_0000_FFFF_FFFF);
      cyc();
      #2;
      chk("lwu_drained", out_valid, 1'b0);

      // flush pulsed in WAIT: bus completes, result is dropped
      in_valid = 1'b1; in_data = mk(1,0,1,1,MSIZE8,0,64'h40,64'h0,9);
      #2;
      for (int k = 0; k < 4; k++) begin
         cyc();
         in_valid = 1'b0; in_data = '0;
         addr_ok = (k == 0); data_ok = (k == 3); flush = (k == 1);
         dresp_data = 64'h1111_2222_3333_4444;
         #2;
         chk("flw_out_valid", out_valid, 1'b0);
         chk("flw_in_ready", in_ready, 1'b0);
      end
      cyc();
      addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0;
      #2;
      chk("flw_after_out_valid", out_valid, 1'b0);
      chk("flw_after_in_ready", in_ready, 1'b1);
      chk("flw_after_dreq", dreq_valid, 1'b0);
      cyc();
      #2;
      chk("flw_stays_idle", out_valid, 1'b0);

      // flush while holding a result
      in_valid = 1'b1; in_data = mk(0,0,0,1,MSIZE8,0,64'h77,64'h0,2);
      #2;
      cyc();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
      #2;
      chk("flh_out_valid", out_valid, 1'b1);
      chk("flh_in_ready", in_ready, 1'b0);
      cyc();
      flush = 1'b0; out_ready = 1'b1;
      #2;
      chk("flh_dropped", out_valid, 1'b0);
      chk("flh_in_ready_after", in_ready, 1'b1);

      // backpressure in HOLD, new op accepted on the release cycle
      in_valid = 1'b1; in_data = mk(0,0,0,1,MSIZE8,0,64'hA1,64'h0,3);
      #2;
      e = mk(0,0,0,1,MSIZE8,0,64'hB2,64'h0,4);
      for (int k = 0; k < 3; k++) begin
         cyc();
         in_valid = 1'b1; in_data = e; out_ready = 1'b0;
         #2;
         chk("bp_out_valid", out_valid, 1'b1);
         chk("bp_stable", out_data.writedata, 64'hA1);
         chk("bp_in_ready", in_ready, 1'b0);
      end
      cyc();
      out_ready = 1'b1;
      #2;
      chk("bp_release_in_ready", in_ready, 1'b1);
      chk("bp_release_data", out_data.writedata, 64'hA1);
      cyc();
      in_valid = 1'b0; in_data = '0;
      #2;
      chk("bp_next_valid", out_valid, 1'b1);
      chk("bp_next_data", out_data.writedata, 64'hB2);
      chk("bp_next_dst", out_data.dst, 5'd4);

      // asynchronous reset in the middle of a request
      cyc();
      in_valid = 1'b1; in_data = mk(1,0,1,1,MSIZE8,0,64'h88,64'h0,8);
      #2;
      cyc();
      in_valid = 1'b0; in_data = '0;
      #2;
      chk("arst_pre_dreq", dreq_valid, 1'b1);
      reset = 1'b1;
      #1;
      chk("arst_dreq_valid", dreq_valid, 1'b0);
      chk("arst_in_ready", in_ready, 1'b1);
      chk("arst_dreq_addr", dreq_addr, 64'h0);
      #1;
      reset = 1'b0;
      cyc();
      #2;
      chk("arst_idle", dreq_valid, 1'b0);

      // randomized traffic against the reference model
      bus_ph = 0;
      for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
      for (int c = 0; c < 40; c++) rnd_cycle(1'b0);
      chk("rnd_drained", expq.size(), 0);
      chk("rnd_bus_idle", bus_ph, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the in-order RV64 pipeline. Consumes one `exec_data_t` from the execute stage, performs the load or store on the data bus with a two-phase (`addr_ok`/`data_ok`) handshake, formats load data, and presents one `mem_data_t` to writeback. It also drives the memory-stage forwarding record. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- `ADDR_W`, 64: data-bus address width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: execute result is valid.
- `in_data` in `exec_data_t`: execute result.
- `in_ready` out 1: stage can accept this cycle.
- `out_valid` out 1: `out_data` is valid.
- `out_data` out `mem_data_t`: result for writeback.
- `out_ready` in 1: writeback accepts.
- `flush` in 1: discard the held or in-flight instruction's result.
- `dreq_valid` out 1: bus request.
- `dreq_addr` out `ADDR_W`: byte address.
- `dreq_size` out `msize_t`: access size.
- `dreq_strobe` out 8: byte-write enables; 0 for loads.
- `dreq_data` out 64: lane-aligned store data.
- `dresp_addr_ok` in 1: request accepted.
- `dresp_data_ok` in 1: access complete.
- `dresp_data` in 64: load data.
- `fwd` out `fwd_data_t`: forwarding record.

## Operation
- State machine with four states:
  - IDLE: empty.
  - REQ: `dreq_valid=1`, waiting for `addr_ok`.
  - WAIT: waiting for `data_ok`.
  - HOLD: result held, `out_valid=1`.
- Ready rule: `in_ready = IDLE | (HOLD & out_ready)`.
- Accept (`in_valid & in_ready`): register `in_data`.
  - If `ctl.mem_read | ctl.mem_write`, go to REQ.
  - Otherwise go to HOLD.
- HOLD exit:
  - `out_ready & !accept`: go to IDLE.
  - `out_ready & accept`: go to REQ or HOLD per the new instruction.
- REQ transitions:
  - `addr_ok & data_ok`: capture `dresp_data`, go to HOLD.
  - `addr_ok` alone: go to WAIT.
  - Request fields stay stable and `dreq_valid` stays 1 until `addr_ok`.
- WAIT transitions:
  - `data_ok`: capture data, go to HOLD.
  - `dreq_valid=0` while in WAIT.
- Address:
  - `dreq_addr = aluout`.
  - Offset `off = aluout[2:0]`.
- Store lane formatting:
  - `dreq_data = memdata << (8*off)`.
  - `dreq_strobe = ((1<<bytes)-1) << off`, truncated to 8 bits.
  - `bytes` is 1, 2, 4 or 8 from `ctl.mem_size`.
- Load lane formatting:
  - `lane = dresp_data >> (8*off)`.
  - Truncate to size.
  - Sign-extend to 64 bits, or zero-extend if `ctl.mem_unsigned`.
- `out_data.writedata` is the formatted load value if `ctl.mem_to_reg`, else `aluout`.
- `ctl`, `dst` and `instr` pass through unchanged.
- Misaligned accesses are outside the contract. No check is made; the request is issued as computed.
- Flush:
  - IDLE/HOLD: go to IDLE immediately; `out_valid` drops the next cycle.
  - REQ/WAIT: the bus transaction completes normally (requests are never withdrawn). The result is then dropped: go to IDLE instead of HOLD.
  - A flush pending flag holds this condition.
  - `in_ready=0` during flush.

## Timing
- Reset values:
  - State IDLE.
  - `out_valid=0`, `out_data=0`.
  - `dreq_valid=0`; `dreq_addr`, `dreq_strobe`, `dreq_data` all 0.
  - `fwd.valid=0`.
  - Flush-pending flag 0.
  - `in_ready=1`.
- Non-memory instruction: accepted cycle N, `out_valid` at N+1.
- Memory instruction:
  - Accepted cycle N, `dreq_valid` from N+1.
  - `data_ok` in cycle M gives `out_valid` at M+1.
  - Minimum latency is 2 cycles, when `addr_ok & data_ok` both arrive at N+1.
- Back-to-back: with `out_ready=1`, one non-memory instruction per cycle.
- Reset mid-transaction: return to IDLE asynchronously. The bus side is reset together with this stage.

## Configuration
- `MEM_FWD_EN` defined:
  - `fwd.valid = HOLD & ctl.reg_write & (dst!=0)`.
  - `fwd.dst = dst`.
  - `fwd.data = out_data.writedata`.
- `MEM_FWD_EN` undefined: `fwd` is tied to 0. The hazard unit must stall on any dependence on this stage.

## Structure
- The shared pipeline package gains:
  - `msize_t` (MSIZE1/2/4/8).
  - `control_t` fields `mem_size` (`msize_t`) and `mem_unsigned` (u1).
  - `exec_data_t` field `memdata` (`word_t`, store data).
  - The state enum `mem_state_t`.
- Natural sub-module: `mem_lane_fmt`, combinational. It implements store shift/strobe and load shift/extend.

## Test plan
- ADD passthrough: `aluout=0x1234`, `reg_write=1`, `dst=5`, `out_ready=1`.
  - `out_valid` one cycle later, `writedata=0x1234`.
  - `fwd={5,0x1234,1}`.
- LB signed: `aluout=0x1003`, `dresp_data=0x0000_0000_8000_0000`, `addr_ok`/`data_ok` the same cycle as the request.
  - `dreq_strobe=0`.
  - `writedata=0xFFFF_FFFF_FFFF_FF80`, 2 cycles after accept.
- SH: `aluout=0x2006`, `memdata=0xABCD`.
  - `dreq_strobe=0xC0`, `dreq_data=0xABCD_0000_0000_0000`.
  - `dreq_valid` held 3 cycles until `addr_ok`.
  - Stores never assert `fwd.valid`.
- LWU with `data_ok` 4 cycles after `addr_ok`: `aluout=0x0`, `dresp_data=0xFFFF_FFFF`.
  - `writedata=0x0000_0000_FFFF_FFFF`.
  - `in_ready=0` throughout REQ/WAIT.
- Flush during WAIT: `flush` pulsed while waiting for `data_ok`.
  - The bus completes.
  - `out_valid` never asserts.
  - State returns to IDLE.
  - `in_ready=1` the cycle after `data_ok`.
- Backpressure: `out_ready=0` for 3 cycles in HOLD.
  - `out_data` is stable and `in_ready=0`.
  - On the release cycle, a new `in_valid` is accepted the same cycle.
